// File: rtl/vit_bmc_acs_ctrl_if.sv
// Received-pair handshake between the demodulator front end
// and the Viterbi frame sequencer.
interface vit_bmc_acs_ctrl_if;
   logic       in_valid;
   logic [1:0] in_pair;
   logic       in_ready;

   modport master (
      output in_valid,
      output in_pair,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_pair,
      output in_ready
   );
endinterface

// File: rtl/vit_bmc_acs_ctrl.sv
// Frame sequencer for the rate-1/2 hard-decision Viterbi core:
// feeds BMC/ACS, addresses survivor memory, kicks traceback.
module vit_bmc_acs_ctrl #(
   parameter int FRAME_LEN = 64,
   parameter int SW        = $clog2(FRAME_LEN)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   vit_bmc_acs_ctrl_if.slave in_if,
   output logic [1:0]    rx_pair,
   output logic          acs_en,
   output logic          acs_init,
   input  logic          pm_msb_all,
   output logic          norm_sub,
   output logic [SW-1:0] step_idx,
   output logic          tb_start,
   input  logic          tb_done,
   output logic          busy,
   output logic          frame_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_RUN,
      S_DRAIN,
      S_TB,
      S_DONE
   } state_e;

   localparam logic [SW:0] LAST = (SW+1)'(FRAME_LEN - 1);
   localparam logic [SW:0] ONE  = (SW+1)'(1);

   state_e        state_q;
   logic [SW:0]   cnt_q;
   logic [SW:0]   cnt_d;
   logic [1:0]    rx_pair_q;
   logic [SW-1:0] step_q;
   logic          acs_en_q;
   logic          acs_init_q;
   logic          in_ready_q;
   logic          tb_start_q;
   logic          busy_q;
   logic          frame_done_q;
   logic          xfer;

   assign xfer  = (state_q == S_RUN) & in_if.in_valid & in_ready_q;
   assign cnt_d = cnt_q + ONE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         rx_pair_q    <= '0;
         step_q       <= '0;
         acs_en_q     <= 1'b0;
         acs_init_q   <= 1'b0;
         in_ready_q   <= 1'b0;
         tb_start_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         // pulse outputs default low; states raise them for one cycle
         acs_en_q     <= 1'b0;
         acs_init_q   <= 1'b0;
         tb_start_q   <= 1'b0;
         frame_done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q    <= S_INIT;
                  acs_init_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            S_INIT: begin
               cnt_q      <= '0;
               in_ready_q <= 1'b1;
               state_q    <= S_RUN;
            end
            S_RUN: begin
               if (xfer) begin
                  rx_pair_q <= in_if.in_pair;
                  acs_en_q  <= 1'b1;
                  step_q    <= cnt_q[SW-1:0];
                  cnt_q     <= cnt_d;
                  if (cnt_q == LAST) begin
                     in_ready_q <= 1'b0;
                     state_q    <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               tb_start_q <= 1'b1;
               state_q    <= S_TB;
            end
            S_TB: begin
               if (tb_done) begin
                  frame_done_q <= 1'b1;
                  state_q      <= S_DONE;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign in_if.in_ready = in_ready_q;
   assign rx_pair        = rx_pair_q;
   assign acs_en         = acs_en_q;
   assign acs_init       = acs_init_q;
   assign step_idx       = step_q;
   assign tb_start       = tb_start_q;
   assign busy           = busy_q;
   assign frame_done     = frame_done_q;

   // pm_msb_all is already registered inside the ACS array
   assign norm_sub = acs_en_q & pm_msb_all;

endmodule

// File: tb/tb_vit_bmc_acs_ctrl.sv
// Scoreboard bench for vit_bmc_acs_ctrl: directed frames,
// monitor pops expected ACS updates on every acs_en.
module tb_vit_bmc_acs_ctrl;
   localparam int FL = 64;
   localparam int SW = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          pm_msb_all = 1'b0;
   logic          tb_done = 1'b0;
   logic [1:0]    rx_pair;
   logic          acs_en;
   logic          acs_init;
   logic          norm_sub;
   logic [SW-1:0] step_idx;
   logic          tb_start;
   logic          busy;
   logic          frame_done;

   vit_bmc_acs_ctrl_if in_if ();

   vit_bmc_acs_ctrl #(.FRAME_LEN(FL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .in_if      (in_if),
      .rx_pair    (rx_pair),
      .acs_en     (acs_en),
      .acs_init   (acs_init),
      .pm_msb_all (pm_msb_all),
      .norm_sub   (norm_sub),
      .step_idx   (step_idx),
      .tb_start   (tb_start),
      .tb_done    (tb_done),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [SW-1:0] step;
      logic [1:0]    pair;
      logic          norm;
   } exp_t;

   exp_t q[$];
   exp_t e_m;
   int checks = 0;
   int failures = 0;
   int n_acs = 0;
   int n_init = 0;
   int n_tbs = 0;
   int n_fd = 0;
   logic [1:0] model_rx = 2'b00;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   // monitor: pops one expected update per acs_en
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         model_rx = 2'b00;
      end else begin
         if (acs_en) begin
            n_acs++;
            chk("sb_nonempty", 32'(q.size() > 0), 1);
            if (q.size() > 0) begin
               e_m = q.pop_front();
               chk("step_idx", 32'(step_idx), 32'(e_m.step));
               chk("rx_pair", 32'(rx_pair), 32'(e_m.pair));
               chk("norm_sub", 32'(norm_sub), 32'(e_m.norm));
               model_rx = e_m.pair;
            end
         end else begin
            if (norm_sub !== 1'b0)
               chk("norm_sub_no_acs", 32'(norm_sub), 0);
            if (rx_pair !== model_rx)
               chk("rx_pair_hold", 32'(rx_pair), 32'(model_rx));
         end
         if (acs_init) n_init++;
         if (tb_start) n_tbs++;
         if (frame_done) n_fd++;
      end
   end

   task automatic chk_all_zero(input string nm);
      chk(nm, {22'd0, in_if.in_ready, acs_en, acs_init, busy,
               tb_start, frame_done, norm_sub, rx_pair, step_idx == 0},
          32'd1);
   endtask

   task automatic run_frame(input bit gap, input bit nrm,
                            input int tb_dly, input bit stray,
                            input int abort_at);
      int   cnt;
      int   cyc;
      int   w;
      bit   pushed;
      exp_t e;
      cnt = 0;
      pushed = 0;
      @(posedge clk); #1;
      n_acs = 0; n_init = 0; n_tbs = 0; n_fd = 0;
      start = 1'b1;
      in_if.in_valid = 1'b1;
      in_if.in_pair = 2'b00;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      cyc = 1;
      chk("acs_init_cycle1", 32'(acs_init), 1);
      chk("busy_init", 32'(busy), 1);
      chk("in_ready_init", 32'(in_if.in_ready), 0);
      while (cnt < FL) begin
         if (abort_at > 0 && cnt == abort_at) begin
            #2 rst_n = 1'b0;
            #1 chk_all_zero("abort_outputs_zero");
            in_if.in_valid = 1'b0;
            @(posedge clk);
            @(posedge clk);
            #2 rst_n = 1'b1;
            return;
         end
         pushed = 0;
         if (in_if.in_valid && in_if.in_ready) begin
            e.step = 6'(cnt);
            e.pair = in_if.in_pair;
            e.norm = nrm && (cnt == 30);
            q.push_back(e);
            cnt++;
            pushed = 1;
         end
         @(posedge clk); #1;
         pm_msb_all = nrm && ((pushed && cnt == 31) ||
                              (!pushed && cnt == 32));
         in_if.in_pair = 2'(cnt);
         if (gap) in_if.in_valid = ~in_if.in_valid;
         tb_done = stray && pushed && (cnt == 10);
         start = stray && pushed && (cnt == 10);
         @(negedge clk);
         cyc++;
         if (cyc > 400) begin
            chk("run_timeout", 32'(cnt), FL);
            return;
         end
      end
      pm_msb_all = 1'b0;
      chk("in_ready_after_last", 32'(in_if.in_ready), 0);
      w = 0;
      while (!tb_start && w < 20) begin
         @(negedge clk);
         w++;
         cyc++;
      end
      chk("tb_start_seen", 32'(tb_start), 1);
      chk("tb_start_latency", 32'(w), 1);
      for (int i = 0; i < tb_dly; i++) begin
         @(negedge clk);
         cyc++;
         chk("busy_in_tb", 32'(busy), 1);
         chk("no_fd_in_tb", 32'(frame_done), 0);
      end
      tb_done = 1'b1;
      @(posedge clk); #1;
      tb_done = 1'b0;
      @(negedge clk);
      cyc++;
      chk("frame_done", 32'(frame_done), 1);
      chk("busy_done", 32'(busy), 1);
      if (!gap && tb_dly == 0)
         chk("frame_cycles", 32'(cyc), FL + 4);
      @(negedge clk);
      chk("frame_done_once", 32'(frame_done), 0);
      chk("busy_idle", 32'(busy), 0);
      in_if.in_valid = 1'b0;
      @(negedge clk);
      chk("acs_en_count", 32'(n_acs), FL);
      chk("acs_init_count", 32'(n_init), 1);
      chk("tb_start_count", 32'(n_tbs), 1);
      chk("frame_done_count", 32'(n_fd), 1);
      chk("sb_empty", 32'(q.size()), 0);
   endtask

   initial begin
      in_if.in_valid = 1'b1;
      in_if.in_pair = 2'b11;
      repeat (3) @(negedge clk);
      chk_all_zero("reset_outputs");
      #2 rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_quiet", {27'd0, in_if.in_ready, acs_en, busy,
                            tb_start, frame_done}, 0);
      end
      in_if.in_valid = 1'b0;

      run_frame(0, 0, 0, 0, 0);

      @(posedge clk); #1 pm_msb_all = 1'b1;
      @(negedge clk);
      chk("norm_sub_idle_msb", 32'(norm_sub), 0);
      @(posedge clk); #1 pm_msb_all = 1'b0;

      run_frame(1, 1, 0, 0, 0);
      run_frame(0, 0, 10, 1, 0);
      run_frame(0, 0, 0, 0, 17);
      repeat (2) @(negedge clk);
      chk_all_zero("post_abort_idle");
      run_frame(0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
